// File: rtl/echo_tap_scheduler_if.sv
// echo_tap_scheduler_if: RAM port and output sample bundle for echo_tap_scheduler.
// Ports: mem_addr/mem_wdata/mem_we/mem_rdata (single-port delay-line RAM), out/out_valid (echo sample).
// master = scheduler side (drives RAM controls and output), slave = RAM/mixer side.
interface echo_tap_scheduler_if #(
   parameter int BITSIZE = 16,
   parameter int ADDR_W  = 14
);
   logic [ADDR_W-1:0]  mem_addr;
   logic [BITSIZE-1:0] mem_wdata;
   logic               mem_we;
   logic [BITSIZE-1:0] mem_rdata;
   logic [BITSIZE-1:0] out;
   logic               out_valid;

   modport master (
      output mem_addr, mem_wdata, mem_we, out, out_valid,
      input  mem_rdata
   );

   modport slave (
      input  mem_addr, mem_wdata, mem_we, out, out_valid,
      output mem_rdata
   );
endinterface

// File: rtl/echo_tap_scheduler.sv
// echo_tap_scheduler: per-frame delay-line sequencer; writes the new sample, reads TAPS delayed
// samples, MACs them with signed Q1.(BITSIZE-1) gains and emits one saturated echo sample per frame.
// Ports: clk/reset (async, active-high), lrclk (async frame clock), enable (0 = bypass), in (sample),
//        tap_offset/tap_gain (packed per-tap), bus (RAM port + out/out_valid), busy, overrun (sticky).
// Latency: out_valid TAPS+3 clks after the registered frame edge (1 clk in bypass).
// Option: define MEM_CLEAR_EN to zero the whole RAM after reset release (busy during the sweep).
module echo_tap_scheduler #(
   parameter int BITSIZE = 16,
   parameter int ADDR_W  = 14,
   parameter int TAPS    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      lrclk,
   input  logic                      enable,
   input  logic [BITSIZE-1:0]        in,
   input  logic [TAPS*ADDR_W-1:0]    tap_offset,
   input  logic [TAPS*BITSIZE-1:0]   tap_gain,
   echo_tap_scheduler_if.master      bus,
   output logic                      busy,
   output logic                      overrun
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] WRITE  = 3'd1;
   localparam logic [2:0] READ   = 3'd2;
   localparam logic [2:0] DRAIN  = 3'd3;
   localparam logic [2:0] DONE   = 3'd4;
   localparam logic [2:0] BYPASS = 3'd5;
   localparam logic [2:0] CLEAR  = 3'd6;

   localparam int IDX_W = 3;
   localparam int ACC_W = 2*BITSIZE + 3;
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(BITSIZE-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2**(BITSIZE-1)));
   localparam logic [IDX_W-1:0] LAST_TAP = IDX_W'(TAPS - 1);

   logic [2:0]                 state;
   logic                       lr_s1, lr_s2, lr_s3;
   logic                       frame_start;
   logic [ADDR_W-1:0]          wr_ptr;
   logic [IDX_W-1:0]           tap_idx;
   logic [IDX_W-1:0]           mac_sel;
   logic                       mac_en;
   logic signed [ACC_W-1:0]    acc;
   logic signed [ACC_W-1:0]    acc_next;
   logic signed [ACC_W-1:0]    acc_shift;
   logic signed [2*BITSIZE-1:0] prod;
   logic signed [BITSIZE-1:0]  gain_sel;
   logic [BITSIZE-1:0]         sat_val;
   logic [IDX_W-1:0]           next_idx;
   logic [ADDR_W-1:0]          tap_addr;
`ifdef MEM_CLEAR_EN
   logic                       clear_pending;
   logic [ADDR_W:0]            clr_cnt;
`endif

   // rising edge of the synchronised frame clock
   assign frame_start = lr_s2 & ~lr_s3;
   assign busy        = (state != IDLE);

   // Address for the tap about to be issued: tap 0 right after WRITE, otherwise the next tap.
   // Offsets are read here, so a mid-frame change only affects taps not yet issued.
   always_comb begin
      next_idx = '0;
      if (state == READ && tap_idx != LAST_TAP)
         next_idx = tap_idx + IDX_W'(1);
      tap_addr = wr_ptr - tap_offset[int'(next_idx)*ADDR_W +: ADDR_W];
   end

   // MAC runs one cycle behind the read address because RAM data returns a clock later.
   always_comb begin
      gain_sel  = tap_gain[int'(mac_sel)*BITSIZE +: BITSIZE];
      prod      = $signed(bus.mem_rdata) * gain_sel;
      acc_next  = acc + {{(ACC_W-2*BITSIZE){prod[2*BITSIZE-1]}}, prod};
      acc_shift = acc_next >>> (BITSIZE-1);
      if (acc_shift > SAT_MAX)
         sat_val = SAT_MAX[BITSIZE-1:0];
      else if (acc_shift < SAT_MIN)
         sat_val = SAT_MIN[BITSIZE-1:0];
      else
         sat_val = acc_shift[BITSIZE-1:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         lr_s1         <= 1'b0;
         lr_s2         <= 1'b0;
         lr_s3         <= 1'b0;
         wr_ptr        <= '0;
         tap_idx       <= '0;
         mac_sel       <= '0;
         mac_en        <= 1'b0;
         acc           <= '0;
         overrun       <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_we    <= 1'b0;
         bus.out       <= '0;
         bus.out_valid <= 1'b0;
`ifdef MEM_CLEAR_EN
         clear_pending <= 1'b1;
         clr_cnt       <= '0;
`endif
      end else begin
         lr_s1 <= lrclk;
         lr_s2 <= lr_s1;
         lr_s3 <= lr_s2;

         bus.mem_we    <= 1'b0;
         bus.out_valid <= 1'b0;

         if (mac_en)
            acc <= acc_next;

         // A frame edge during the clear sweep is dropped silently; any other busy state flags it.
         if (frame_start && state != IDLE && state != CLEAR)
            overrun <= 1'b1;

         case (state)
            IDLE: begin
`ifdef MEM_CLEAR_EN
               if (clear_pending) begin
                  clear_pending <= 1'b0;
                  clr_cnt       <= '0;
                  state         <= CLEAR;
               end else
`endif
               if (frame_start) begin
                  if (enable) begin
                     bus.mem_we    <= 1'b1;
                     bus.mem_addr  <= wr_ptr;
                     bus.mem_wdata <= in;
                     state         <= WRITE;
                  end else begin
                     bus.out       <= in;
                     bus.out_valid <= 1'b1;
                     state         <= BYPASS;
                  end
               end
            end
            WRITE: begin
               acc          <= '0;
               tap_idx      <= '0;
               bus.mem_addr <= tap_addr;
               state        <= READ;
            end
            READ: begin
               mac_en  <= 1'b1;
               mac_sel <= tap_idx;
               if (tap_idx == LAST_TAP) begin
                  state <= DRAIN;
               end else begin
                  tap_idx      <= next_idx;
                  bus.mem_addr <= tap_addr;
               end
            end
            DRAIN: begin
               mac_en        <= 1'b0;
               bus.out       <= sat_val;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               wr_ptr <= wr_ptr + ADDR_W'(1);
               state  <= IDLE;
            end
            BYPASS: begin
               state <= IDLE;
            end
`ifdef MEM_CLEAR_EN
            CLEAR: begin
               if (clr_cnt == (ADDR_W+1)'(2**ADDR_W)) begin
                  state <= IDLE;
               end else begin
                  bus.mem_we    <= 1'b1;
                  bus.mem_addr  <= clr_cnt[ADDR_W-1:0];
                  bus.mem_wdata <= '0;
                  clr_cnt       <= clr_cnt + (ADDR_W+1)'(1);
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_echo_tap_scheduler.sv
// tb_echo_tap_scheduler: scoreboard bench for echo_tap_scheduler (BITSIZE=16, ADDR_W=4, TAPS=2)
// with a 1-cycle behavioural RAM; a reference model of the delay line produces expected samples.
// Ports: drives clk/reset/lrclk/enable/in/taps, models the RAM on the slave side of the interface.
module tb_echo_tap_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic        lrclk;
   logic        enable;
   logic [15:0] din;
   logic [7:0]  tap_offset;
   logic [31:0] tap_gain;
   logic        busy;
   logic        overrun;

   int tests_run    = 0;
   int tests_failed = 0;
   int bypass_we    = 0;

   logic [15:0] sb[$];
   logic [15:0] m_mem [16];
   int          m_wp;
   logic        prev_valid = 1'b0;
   logic [15:0] ram [16] = '{default: 16'h0000};

   echo_tap_scheduler_if #(.BITSIZE(16), .ADDR_W(4)) bus ();

   echo_tap_scheduler #(.BITSIZE(16), .ADDR_W(4), .TAPS(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .lrclk      (lrclk),
      .enable     (enable),
      .in         (din),
      .tap_offset (tap_offset),
      .tap_gain   (tap_gain),
      .bus        (bus),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   // single-port RAM, read data registered one clock after the address
   always @(posedge clk) begin
      if (bus.mem_we)
         ram[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= ram[bus.mem_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!reset) begin
         if (bus.mem_we && !enable)
            bypass_we++;
         if (bus.out_valid) begin
            if (prev_valid)
               check("valid_pulse", 32'd1, 32'd0);
            if (sb.size() == 0)
               check("unexpected_out", {16'h0, bus.out}, 32'hFFFF_FFFF);
            else
               check("out", {16'h0, bus.out}, {16'h0, sb.pop_front()});
         end
         prev_valid = bus.out_valid;
      end else begin
         prev_valid = 1'b0;
      end
   end

   function automatic logic [15:0] sat16(input longint a);
      longint s;
      s = a >>> 15;
      if (s > 32767)  return 16'h7FFF;
      if (s < -32768) return 16'h8000;
      return s[15:0];
   endfunction

   // reference model of one frame; updates model RAM/pointer, returns expected output
   function automatic logic [15:0] model_frame(input logic [15:0] d, input logic en);
      longint acc;
      int     a;
      if (!en) return d;
      m_mem[m_wp] = d;
      acc = 0;
      for (int i = 0; i < 2; i++) begin
         a = (m_wp - int'(tap_offset[i*4 +: 4])) & 15;
         acc += longint'($signed(m_mem[a])) * longint'($signed(tap_gain[i*16 +: 16]));
      end
      m_wp = (m_wp + 1) % 16;
      return sat16(acc);
   endfunction

   task automatic frame(input logic [15:0] d, input logic en, input logic use_const,
                        input logic [15:0] cexp);
      logic [15:0] e;
      e = model_frame(d, en);
      sb.push_back(use_const ? cexp : e);
      din    = d;
      enable = en;
      @(negedge clk);
      lrclk = 1'b1;
      repeat (8) @(negedge clk);
      lrclk = 1'b0;
      repeat (8) @(negedge clk);
      enable = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 32'd1, 32'd0);
   endtask

   task automatic wait_busy(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("busy_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      bit          ok;
      int          nw;
      int          bad;
      logic [15:0] imp_exp [6];

      reset      = 1'b1;
      lrclk      = 1'b0;
      enable     = 1'b1;
      din        = '0;
      tap_offset = '0;
      tap_gain   = '0;
      m_wp       = 0;
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;

      repeat (3) @(negedge clk);
      check("rst_out",       {16'h0, bus.out},       32'h0);
      check("rst_out_valid", {31'h0, bus.out_valid}, 32'h0);
      check("rst_mem_we",    {31'h0, bus.mem_we},    32'h0);
      check("rst_mem_addr",  {28'h0, bus.mem_addr},  32'h0);
      check("rst_mem_wdata", {16'h0, bus.mem_wdata}, 32'h0);
      check("rst_busy",      {31'h0, busy},          32'h0);
      check("rst_overrun",   {31'h0, overrun},       32'h0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      wait_idle();

      // single tap, unity-ish gain
      tap_offset = {4'd0, 4'd0};
      tap_gain   = {16'h0000, 16'h7FFF};
      frame(16'h1000, 1'b1, 1'b1, 16'h0FFF);
      check("busy_after", {31'h0, busy}, 32'h0);

      // bypass: output follows input, RAM untouched, pointer frozen
      frame(16'h5A5A, 1'b0, 1'b1, 16'h5A5A);
      frame(16'h8001, 1'b0, 1'b1, 16'h8001);
      check("bypass_no_we", bypass_we, 0);

      // impulse response with a 3-sample echo; flush the line with zeros first
      tap_offset = {4'd0, 4'd3};
      tap_gain   = {16'h4000, 16'h4000};
      for (int i = 0; i < 16; i++) frame(16'h0000, 1'b1, 1'b0, 16'h0);
      imp_exp = '{16'h1000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000};
      for (int i = 0; i < 6; i++)
         frame((i == 0) ? 16'h2000 : 16'h0000, 1'b1, 1'b1, imp_exp[i]);

      // positive and negative saturation
      tap_offset = {4'd15, 4'd0};
      tap_gain   = {16'h7FFF, 16'h7FFF};
      for (int i = 0; i < 16; i++) frame(16'h7FFF, 1'b1, 1'b0, 16'h0);
      frame(16'h7FFF, 1'b1, 1'b1, 16'h7FFF);
      for (int i = 0; i < 16; i++) frame(16'h8000, 1'b1, 1'b0, 16'h0);
      frame(16'h8000, 1'b1, 1'b1, 16'h8000);

      // address wrap: start at wr_ptr 14 with a maximal offset, random data and gains
      tap_gain = {16'h2000, 16'h3000};
      while (m_wp != 14) frame(16'($urandom), 1'b1, 1'b0, 16'h0);
      for (int i = 0; i < 20; i++) begin
         tap_offset = {4'($urandom_range(0, 15)), 4'd15};
         tap_gain   = {16'($urandom), 16'($urandom)};
         frame(16'($urandom), 1'b1, 1'b0, 16'h0);
      end

      // overrun: second frame edge while busy is ignored, current frame still completes
      check("ovr_clear", {31'h0, overrun}, 32'h0);
      tap_offset = {4'd2, 4'd1};
      tap_gain   = {16'h1234, 16'hC000};
      din        = 16'h4321;
      enable     = 1'b1;
      sb.push_back(model_frame(16'h4321, 1'b1));
      @(negedge clk);
      lrclk = 1'b1;
      wait_busy(ok);
      lrclk = 1'b0;
      @(negedge clk);
      lrclk = 1'b1;
      repeat (12) @(negedge clk);
      check("ovr_set", {31'h0, overrun}, 32'h1);
      lrclk = 1'b0;
      repeat (8) @(negedge clk);
      frame(16'h0777, 1'b1, 1'b0, 16'h0);
      check("ovr_sticky", {31'h0, overrun}, 32'h1);

      // reset in the middle of a frame (third cycle)
      tap_offset = {4'd15, 4'd0};
      tap_gain   = {16'h6000, 16'h5000};
      din        = 16'h1234;
      @(negedge clk);
      lrclk = 1'b1;
      wait_busy(ok);
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_we",      {31'h0, bus.mem_we},    32'h0);
      check("mid_rst_busy",    {31'h0, busy},          32'h0);
      check("mid_rst_out",     {16'h0, bus.out},       32'h0);
      check("mid_rst_overrun", {31'h0, overrun},       32'h0);
      m_mem[m_wp] = 16'h1234;
      m_wp        = 0;
      lrclk       = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      nw  = 0;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.mem_we) begin
            if (bus.mem_wdata != 16'h0 || bus.mem_addr != nw[3:0]) bad++;
            nw++;
         end
      end
`ifdef MEM_CLEAR_EN
      check("clr_writes", nw, 16);
      check("clr_data", bad, 0);
      for (int i = 0; i < 16; i++) m_mem[i] = 16'h0;
`else
      check("no_clr_writes", nw, 0);
`endif
      wait_idle();
      for (int i = 0; i < 3; i++) frame(16'(16'h0100 * (i + 1)), 1'b1, 1'b0, 16'h0);

      repeat (4) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
